data_mem_arbiter: RTL and testbench

Shares the single-port byte-addressed data memory between two requesters: port 0 (CPU load/store stage) and port 1 (loader/debug master). Each request is arbitrated round-robin, checked for alignment and range, then sequenced as one memory access cycle followed by a one-cycle registered response. It sits between the requesters and the data memory's `clk/WE/addr_mode/A/WD/RD` port, and is the only block that drives that port.

---
 rtl/data_mem_arbiter_pkg.sv | 34 +++
 rtl/data_mem_arbiter_if.sv | 52 +++++
 rtl/data_mem_arbiter_rr_pick2.sv | 13 +
 rtl/data_mem_arbiter.sv | 98 +++++++++
 tb/tb_data_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM states, access modes, request record, range check.
// Pure package, no logic of its own.
package dmem_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;
  localparam longint unsigned DMEM_MEM_BYTES = 64'd131072;

  localparam logic ACC_WORD = 1'b0;
  localparam logic ACC_BYTE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic               we;
    logic               is_byte;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } req_t;

  // The last touched byte is computed one bit wider so addresses near the top never wrap.
  function automatic logic access_err(input logic               is_byte,
                                      input logic [DMEM_AW-1:0] addr,
                                      input logic [DMEM_AW:0]   limit);
    logic [DMEM_AW:0] last_byte;
    last_byte = {1'b0, addr} + ((is_byte == ACC_BYTE) ? '0 : (DMEM_AW+1)'(3));
    return ((is_byte == ACC_WORD) && (addr[1:0] != 2'b00)) || (last_byte >= limit);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-port bundle for the data memory arbiter.
// master = requesters plus memory, slave = the arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     p0_req;
  logic                     p0_we;
  logic                     p0_byte;
  logic [ADDRESS_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0]    p0_wdata;
  logic                     p0_gnt;
  logic                     p0_done;
  logic                     p0_err;
  logic [DATA_WIDTH-1:0]    p0_rdata;

  logic                     p1_req;
  logic                     p1_we;
  logic                     p1_byte;
  logic [ADDRESS_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0]    p1_wdata;
  logic                     p1_gnt;
  logic                     p1_done;
  logic                     p1_err;
  logic [DATA_WIDTH-1:0]    p1_rdata;

  logic                     mem_we;
  logic                     mem_addr_mode;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [DATA_WIDTH-1:0]    mem_rd;

  modport master (
    output p0_req, p0_we, p0_byte, p0_addr, p0_wdata,
    input  p0_gnt, p0_done, p0_err, p0_rdata,
    output p1_req, p1_we, p1_byte, p1_addr, p1_wdata,
    input  p1_gnt, p1_done, p1_err, p1_rdata,
    input  mem_we, mem_addr_mode, mem_a, mem_wd,
    output mem_rd
  );

  modport slave (
    input  p0_req, p0_we, p0_byte, p0_addr, p0_wdata,
    output p0_gnt, p0_done, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_byte, p1_addr, p1_wdata,
    output p1_gnt, p1_done, p1_err, p1_rdata,
    output mem_we, mem_addr_mode, mem_a, mem_wd,
    input  mem_rd
  );

endinterface

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker, combinational (zero latency); a lone requester always wins,
// a tie goes to the port that was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  assign valid = |req;
  assign sel   = (&req) ? ~last : req[1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: grant in T, access in T+1, done in T+2.
// Losers hold req and are served at the next IDLE/RESP cycle; one access in flight at a time.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int              ADDRESS_WIDTH = DMEM_AW,
  parameter int              DATA_WIDTH    = DMEM_DW,
  parameter longint unsigned MEM_BYTES     = DMEM_MEM_BYTES
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  localparam logic [ADDRESS_WIDTH:0] LP_LIMIT = (ADDRESS_WIDTH+1)'(MEM_BYTES);

  state_t                r_state;
  req_t                  r_req;
  logic                  r_err;
  logic                  r_owner;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic       w_open;
  logic [1:0] w_req;
  logic       w_grant;
  logic       w_sel;
  logic       w_err;
  logic       w_resp;
  req_t       w_p0_req;
  req_t       w_p1_req;
  req_t       w_sel_req;

  // Arbitration is closed while an access is on the memory port or reset is asserted.
  assign w_open = (r_state != ST_ACCESS) && !rst;
  assign w_req  = {bus.p1_req, bus.p0_req} & {2{w_open}};

  rr_pick2 u_pick (
    .req   (w_req),
    .last  (r_last),
    .valid (w_grant),
    .sel   (w_sel)
  );

  assign w_p0_req  = '{we: bus.p0_we, is_byte: bus.p0_byte, addr: bus.p0_addr, wdata: bus.p0_wdata};
  assign w_p1_req  = '{we: bus.p1_we, is_byte: bus.p1_byte, addr: bus.p1_addr, wdata: bus.p1_wdata};
  assign w_sel_req = w_sel ? w_p1_req : w_p0_req;
  assign w_err     = access_err(w_sel_req.is_byte, w_sel_req.addr, LP_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_err   <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_grant) begin
            r_req   <= w_sel_req;
            r_err   <= w_err;
            r_owner <= w_sel;
            r_last  <= w_sel;
            r_state <= ST_ACCESS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          r_rdata <= (r_req.we || r_err) ? '0 : bus.mem_rd;
          r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.p0_gnt = w_grant & ~w_sel;
  assign bus.p1_gnt = w_grant &  w_sel;

  // Reset in the response cycle swallows the done pulse.
  assign w_resp       = (r_state == ST_RESP) && !rst;
  assign bus.p0_done  = w_resp & ~r_owner;
  assign bus.p1_done  = w_resp &  r_owner;
  assign bus.p0_err   = bus.p0_done & r_err;
  assign bus.p1_err   = bus.p1_done & r_err;
  assign bus.p0_rdata = bus.p0_done ? r_rdata : '0;
  assign bus.p1_rdata = bus.p1_done ? r_rdata : '0;

  // Address and data simply hold the latched request between accesses.
  assign bus.mem_we        = (r_state == ST_ACCESS) && r_req.we && !r_err && !rst;
  assign bus.mem_addr_mode = r_req.is_byte;
  assign bus.mem_a         = r_req.addr;
  assign bus.mem_wd        = r_req.wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter with a byte-array reference model and round-robin model.
module tb_data_mem_arbiter;

  localparam int MEMB = 131072;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   model_last;

  bit [7:0] mem     [0:MEMB-1];
  bit [7:0] ref_mem [0:MEMB-1];

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Memory behind the port: little-endian, combinational read, write on the rising edge.
  always_comb begin
    bus.mem_rd = '0;
    if (bus.mem_addr_mode) begin
      if (bus.mem_a < 32'(MEMB))
        bus.mem_rd = {24'h0, mem[int'(bus.mem_a)]};
    end else if (bus.mem_a <= 32'(MEMB - 4)) begin
      bus.mem_rd = {mem[int'(bus.mem_a)+3], mem[int'(bus.mem_a)+2],
                    mem[int'(bus.mem_a)+1], mem[int'(bus.mem_a)]};
    end
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_addr_mode) begin
        if (bus.mem_a < 32'(MEMB)) mem[int'(bus.mem_a)] <= bus.mem_wd[7:0];
      end else if (bus.mem_a <= 32'(MEMB - 4)) begin
        for (int i = 0; i < 4; i++) mem[int'(bus.mem_a)+i] <= bus.mem_wd[8*i +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: an access touches 1 or 4 bytes starting at addr; it is rejected when
  // a word is not 4-aligned or any touched byte lies beyond the memory.
  task automatic model_access(input logic we, input logic bt, input logic [31:0] a,
                              input logic [31:0] wd, output logic err, output logic [31:0] rd);
    longint unsigned la;
    int span;
    la   = longint'(a);
    span = bt ? 1 : 4;
    err  = (!bt && (a % 4 != 0)) || (la + longint'(span) > longint'(MEMB));
    rd   = '0;
    if (!err) begin
      for (int i = 0; i < span; i++) begin
        if (we) ref_mem[int'(la) + i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[int'(la) + i];
      end
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic we, input logic bt,
                         input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      bus.p0_req = r; bus.p0_we = we; bus.p0_byte = bt; bus.p0_addr = a; bus.p0_wdata = wd;
    end else begin
      bus.p1_req = r; bus.p1_we = we; bus.p1_byte = bt; bus.p1_addr = a; bus.p1_wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
  endfunction
  function automatic logic done_of(input int p);
    return (p == 0) ? bus.p0_done : bus.p1_done;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? bus.p0_err : bus.p1_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctrl"}, {bus.p0_gnt, bus.p0_done, bus.p0_err, bus.p1_gnt, bus.p1_done,
                              bus.p1_err, bus.mem_we, bus.mem_addr_mode}, 64'h0);
    check_eq({tag, "_rdata"}, {bus.p0_rdata, bus.p1_rdata}, 64'h0);
    check_eq({tag, "_mem_a"}, bus.mem_a, 64'h0);
    check_eq({tag, "_mem_wd"}, bus.mem_wd, 64'h0);
  endtask

  task automatic single_txn(input int p, input logic we, input logic bt, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        seen;
    @(posedge clk); #1;
    set_req(p, 1'b1, we, bt, a, wd);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = gnt_of(p);
    end
    check_eq("txn_gnt", seen, 1);
    model_access(we, bt, a, wd, exp_err, exp_rd);
    model_last = p;
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("txn_done_early", done_of(p), 0);
    check_eq("txn_mem_we", bus.mem_we, we & ~exp_err);
    check_eq("txn_mem_a", {bus.mem_addr_mode, bus.mem_a}, {bt, a});
    @(negedge clk);
    check_eq("txn_done", done_of(p), 1);
    check_eq("txn_err", err_of(p), exp_err);
    check_eq("txn_rdata", rdata_of(p), exp_rd);
    got_rd  = rdata_of(p);
    got_err = err_of(p);
  endtask

  task automatic pair_txn(input logic [1:0] we, input logic [1:0] bt,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] wd0, input logic [31:0] wd1);
    int w;
    int l;
    logic [31:0] aa [2];
    logic [31:0] ww [2];
    logic        exp_err;
    logic [31:0] exp_rd;
    aa[0] = a0; aa[1] = a1; ww[0] = wd0; ww[1] = wd1;
    w = 1 - model_last;
    l = model_last;
    @(posedge clk); #1;
    set_req(0, 1'b1, we[0], bt[0], a0, wd0);
    set_req(1, 1'b1, we[1], bt[1], a1, wd1);
    @(negedge clk);
    check_eq("pair_gnt_win", gnt_of(w), 1);
    check_eq("pair_gnt_lose", gnt_of(l), 0);
    model_access(we[w], bt[w], aa[w], ww[w], exp_err, exp_rd);
    @(posedge clk); #1;
    set_req(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("pair_done_win", done_of(w), 1);
    check_eq("pair_err_win", err_of(w), exp_err);
    check_eq("pair_rdata_win", rdata_of(w), exp_rd);
    check_eq("pair_gnt_next", gnt_of(l), 1);
    model_access(we[l], bt[l], aa[l], ww[l], exp_err, exp_rd);
    model_last = l;
    @(posedge clk); #1;
    set_req(l, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("pair_done_lose", done_of(l), 1);
    check_eq("pair_err_lose", err_of(l), exp_err);
    check_eq("pair_rdata_lose", rdata_of(l), exp_rd);
  endtask

  function automatic logic [31:0] rand_addr(input logic bt);
    logic [31:0] a;
    int s;
    s = $urandom_range(0, 9);
    if (s < 7)      a = 32'h10000 + 32'($urandom_range(0, 63));
    else if (s < 9) a = 32'h1FFF0 + 32'($urandom_range(0, 31));
    else            a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
    if (!bt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [7:0]  g0, g1, d0, d1;
    logic        rbt;
    logic [1:0]  pwe, pbt;
    logic [31:0] pa0, pa1;
    n_checks   = 0;
    n_errors   = 0;
    model_last = 1;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_held");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("reset_idle");

    // Store interrupted by reset while on the memory port.
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h10000, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("rstw_gnt", bus.p0_gnt, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstw_we_suppressed", bus.mem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1;
    @(negedge clk);
    check_quiet("rstw_after");
    check_eq("rstw_mem", {mem[32'h10003], mem[32'h10002], mem[32'h10001], mem[32'h10000]}, 64'h0);
    @(negedge clk);
    check_eq("rstw_no_done", {bus.p0_done, bus.p1_done}, 0);

    // Both ports requesting continuously: strict alternation starting with port 0.
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h10100, 32'h11111111);
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h10200, 32'h22222222);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g0[c] = bus.p0_gnt; g1[c] = bus.p1_gnt;
      d0[c] = bus.p0_done; d1[c] = bus.p1_done;
      if (c == 4) begin
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    check_eq("sim_gnt0", g0, 8'b0001_0001);
    check_eq("sim_gnt1", g1, 8'b0000_0100);
    check_eq("sim_done0", d0, 8'b0100_0100);
    check_eq("sim_done1", d1, 8'b0001_0000);
    model_access(1'b1, 1'b0, 32'h10100, 32'h11111111, er, rd);
    model_access(1'b1, 1'b0, 32'h10200, 32'h22222222, er, rd);
    model_last = 0;

    single_txn(0, 1'b1, 1'b0, 32'h10000, 32'hDEADBEEF, rd, er);
    single_txn(0, 1'b0, 1'b0, 32'h10000, 32'h0, rd, er);
    check_eq("word_load_val", rd, 64'hDEADBEEF);
    check_eq("word_load_err", er, 0);
    single_txn(1, 1'b0, 1'b1, 32'h10002, 32'h0, rd, er);
    check_eq("byte_load_val", rd, 64'h000000AD);
    single_txn(0, 1'b0, 1'b0, 32'h10001, 32'h0, rd, er);
    check_eq("misaligned_err", er, 1);
    check_eq("misaligned_rdata", rd, 0);
    single_txn(1, 1'b1, 1'b0, 32'h1FFFE, 32'hCAFEF00D, rd, er);
    check_eq("oor_word_err", er, 1);
    check_eq("oor_word_mem", {mem[32'h1FFFF], mem[32'h1FFFE]}, 0);
    single_txn(1, 1'b1, 1'b1, 32'h1FFFF, 32'h0000005A, rd, er);
    check_eq("top_byte_err", er, 0);
    check_eq("top_byte_mem", mem[32'h1FFFF], 64'h5A);
    single_txn(0, 1'b0, 1'b0, 32'h10100, 32'h0, rd, er);
    check_eq("sim_store0_val", rd, 64'h11111111);
    single_txn(1, 1'b0, 1'b0, 32'h10200, 32'h0, rd, er);
    check_eq("sim_store1_val", rd, 64'h22222222);

    for (int n = 0; n < 50; n++) begin
      rbt = 1'($urandom_range(0, 1));
      single_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), rbt, rand_addr(rbt),
                 $urandom, rd, er);
    end

    for (int n = 0; n < 20; n++) begin
      pwe = 2'($urandom_range(0, 3));
      pbt = 2'($urandom_range(0, 3));
      pa0 = rand_addr(pbt[0]);
      pa1 = ($urandom_range(0, 1) == 1) ? pa0 : rand_addr(pbt[1]);
      pair_txn(pwe, pbt, pa0, pa1, $urandom, $urandom);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
